stpw_cmd_ctrl: RTL and testbench

STPW_CMD_CTRL -- requirements
Module: stpw_cmd_ctrl

---
 rtl/stpw_pkg.sv | 40 ++++
 rtl/stpw_cmd_decode.sv | 30 +++
 rtl/stpw_cmd_ctrl.sv | 155 +++++++++++++++
 tb/tb_stpw_cmd_ctrl.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/stpw_pkg.sv
// Shared definitions for the stopwatch command controller.
// Contents: FSM state encoding, command codes, echo ASCII bytes and the UART byte decoder.
package stpw_pkg;

    typedef enum logic [1:0] {
        ST_STOP  = 2'd0,
        ST_RUN   = 2'd1,
        ST_CLEAR = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        CMD_NONE    = 3'd0,
        CMD_TOGGLE  = 3'd1,
        CMD_CLEAR   = 3'd2,
        CMD_LAP     = 3'd3,
        CMD_INVALID = 3'd4
    } cmd_t;

    localparam logic [7:0] ASC_R_UP = 8'h52;
    localparam logic [7:0] ASC_R_LO = 8'h72;
    localparam logic [7:0] ASC_S_UP = 8'h53;
    localparam logic [7:0] ASC_C_UP = 8'h43;
    localparam logic [7:0] ASC_C_LO = 8'h63;
    localparam logic [7:0] ASC_L_UP = 8'h4C;
    localparam logic [7:0] ASC_L_LO = 8'h6C;
    localparam logic [7:0] ASC_QM   = 8'h3F;

    // Map one received byte to a command; anything unrecognised is INVALID.
    function automatic cmd_t decode_byte(input logic [7:0] b);
        cmd_t c;
        case (b)
            ASC_R_UP, ASC_R_LO: c = CMD_TOGGLE;
            ASC_C_UP, ASC_C_LO: c = CMD_CLEAR;
            ASC_L_UP, ASC_L_LO: c = CMD_LAP;
            default:            c = CMD_INVALID;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/stpw_cmd_decode.sv
// Merges button pulses and UART bytes into one command per cycle.
// Buttons outrank the UART, and btn_run outranks btn_clr.
module stpw_cmd_decode
    import stpw_pkg::*;
(
    input  logic       btn_run,
    input  logic       btn_clr,
    input  logic [7:0] rx_data,
    input  logic       rx_done,
    output cmd_t       cmd,
    output logic       from_uart
);

    // Source priority select
    always_comb begin
        cmd       = CMD_NONE;
        from_uart = 1'b0;
        if (btn_run) begin
            cmd = CMD_TOGGLE;
        end else if (btn_clr) begin
            cmd = CMD_CLEAR;
        end else if (rx_done) begin
            cmd       = decode_byte(rx_data);
            from_uart = 1'b1;
        end else begin
            cmd = CMD_NONE;
        end
    end

endmodule

// File: rtl/stpw_cmd_ctrl.sv
// Stopwatch command controller: run/stop/clear FSM, lap capture and a one-deep echo buffer.
// An echo is staged one cycle after the command and enters the buffer on the following edge.
module stpw_cmd_ctrl
    import stpw_pkg::*;
#(
    parameter bit ECHO_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        btn_run,
    input  logic        btn_clr,
    input  logic [7:0]  rx_data,
    input  logic        rx_done,
    input  logic [23:0] stpw_data,
    input  logic        tx_busy,
    output logic        run,
    output logic        clr,
    output logic [23:0] lap_data,
    output logic        lap_valid,
    output logic        tx_start,
    output logic [7:0]  tx_data,
    output logic        tx_ovf,
    output logic [1:0]  state
);

    cmd_t        cmd_s;
    logic        from_uart_s;
    state_t      nxt_s;
    logic        echo_req_s;
    logic [7:0]  echo_code_s;
    logic        lap_take_s;
    logic        fire_s;

    state_t      state_r;
    logic        run_r;
    logic        clr_r;
    logic [23:0] lap_data_r;
    logic        lap_valid_r;
    logic        echo_vld_r;
    logic [7:0]  echo_byte_r;
    logic        pend_r;
    logic [7:0]  tx_data_r;
    logic        ovf_r;

    stpw_cmd_decode u_decode (
        .btn_run   (btn_run),
        .btn_clr   (btn_clr),
        .rx_data   (rx_data),
        .rx_done   (rx_done),
        .cmd       (cmd_s),
        .from_uart (from_uart_s)
    );

    // Command acceptance: next state, lap capture and which echo to emit
    always_comb begin
        nxt_s       = state_r;
        echo_req_s  = 1'b0;
        echo_code_s = ASC_QM;
        lap_take_s  = 1'b0;
        case (state_r)
            ST_STOP: begin
                case (cmd_s)
                    CMD_TOGGLE: begin
                        nxt_s       = ST_RUN;
                        echo_req_s  = 1'b1;
                        echo_code_s = ASC_R_UP;
                    end
                    CMD_CLEAR: begin
                        nxt_s       = ST_CLEAR;
                        echo_req_s  = 1'b1;
                        echo_code_s = ASC_C_UP;
                    end
                    CMD_LAP, CMD_INVALID: echo_req_s = from_uart_s;
                    default: echo_req_s = 1'b0;
                endcase
            end
            ST_RUN: begin
                case (cmd_s)
                    CMD_TOGGLE: begin
                        nxt_s       = ST_STOP;
                        echo_req_s  = 1'b1;
                        echo_code_s = ASC_S_UP;
                    end
                    CMD_LAP: begin
                        lap_take_s  = 1'b1;
                        echo_req_s  = 1'b1;
                        echo_code_s = ASC_L_UP;
                    end
                    CMD_CLEAR, CMD_INVALID: echo_req_s = from_uart_s;
                    default: echo_req_s = 1'b0;
                endcase
            end
            ST_CLEAR: begin
                nxt_s      = ST_STOP;
                echo_req_s = from_uart_s && (cmd_s != CMD_NONE);
            end
            default: begin
                // unreachable encoding: recover to STOP, treat any command as ignored
                nxt_s      = ST_STOP;
                echo_req_s = from_uart_s && (cmd_s != CMD_NONE);
            end
        endcase
    end

    // FSM state, registered mode outputs, lap register and echo staging
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r     <= ST_STOP;
            run_r       <= 1'b0;
            clr_r       <= 1'b0;
            lap_data_r  <= 24'h000000;
            lap_valid_r <= 1'b0;
            echo_vld_r  <= 1'b0;
            echo_byte_r <= 8'h00;
        end else begin
            state_r     <= nxt_s;
            run_r       <= (nxt_s == ST_RUN);
            clr_r       <= (nxt_s == ST_CLEAR);
            lap_valid_r <= lap_take_s;
            if (lap_take_s) begin
                lap_data_r <= stpw_data;
            end
            echo_vld_r  <= ECHO_EN && echo_req_s;
            echo_byte_r <= echo_code_s;
        end
    end

    assign fire_s = pend_r && !tx_busy;

    // One-entry echo buffer; a send frees the slot on the same edge a new echo may take it
    always_ff @(posedge clk) begin
        if (!rst) begin
            pend_r    <= 1'b0;
            tx_data_r <= 8'h00;
            ovf_r     <= 1'b0;
        end else if (echo_vld_r && (!pend_r || fire_s)) begin
            pend_r    <= 1'b1;
            tx_data_r <= echo_byte_r;
        end else if (echo_vld_r) begin
            ovf_r <= 1'b1;
        end else if (fire_s) begin
            pend_r <= 1'b0;
        end
    end

    assign run       = run_r;
    assign clr       = clr_r;
    assign lap_data  = lap_data_r;
    assign lap_valid = lap_valid_r;
    assign tx_start  = fire_s;
    assign tx_data   = tx_data_r;
    assign tx_ovf    = ovf_r;
    assign state     = state_r;

endmodule

// File: tb/tb_stpw_cmd_ctrl.sv
// Scoreboard bench for stpw_cmd_ctrl: a command-level reference model predicts mode,
// lap captures and echo bytes; a negedge monitor pops and compares what the DUT presents.
module tb_stpw_cmd_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        btn_run = 1'b0;
    logic        btn_clr = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_done = 1'b0;
    logic [23:0] stpw_data = 24'h000000;
    logic        tx_busy = 1'b0;
    logic        run, clr, lap_valid, tx_start, tx_ovf;
    logic [23:0] lap_data;
    logic [7:0]  tx_data;
    logic [1:0]  state;

    stpw_cmd_ctrl #(.ECHO_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .btn_run(btn_run), .btn_clr(btn_clr),
        .rx_data(rx_data), .rx_done(rx_done), .stpw_data(stpw_data),
        .tx_busy(tx_busy), .run(run), .clr(clr), .lap_data(lap_data),
        .lap_valid(lap_valid), .tx_start(tx_start), .tx_data(tx_data),
        .tx_ovf(tx_ovf), .state(state)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: mode 0=stop 1=run 2=clear
    int          m_mode = 0;
    bit          m_lapv = 1'b0;
    bit          m_ovf = 1'b0;
    bit          mon_en = 1'b0;
    logic [23:0] m_lap = 24'h000000;
    bit          arr_v = 1'b0;
    logic [7:0]  arr_b = 8'h00;
    logic [7:0]  buf_q[$];
    logic [7:0]  exp_tx_q[$];
    logic [23:0] exp_lap_q[$];

    always @(posedge clk) begin
        int c;
        bit uart, acc;
        int old;
        logic [7:0] eb;
        if (!rst) begin
            m_mode = 0; m_lapv = 1'b0; m_ovf = 1'b0; m_lap = 24'h000000;
            arr_v = 1'b0;
            buf_q.delete(); exp_tx_q.delete(); exp_lap_q.delete();
            mon_en = 1'b1;
        end else begin
            // echo buffer: at most one byte waiting; a send this cycle makes room
            if (buf_q.size() != 0 && !tx_busy) void'(buf_q.pop_front());
            if (arr_v) begin
                if (buf_q.size() != 0) m_ovf = 1'b1;
                else begin
                    buf_q.push_back(arr_b);
                    exp_tx_q.push_back(arr_b);
                end
            end
            arr_v = 1'b0;
            // classify the command of this cycle
            c = 0; uart = 1'b0;
            if (btn_run) c = 1;
            else if (btn_clr) c = 2;
            else if (rx_done) begin
                uart = 1'b1;
                if (rx_data == "R" || rx_data == "r") c = 1;
                else if (rx_data == "C" || rx_data == "c") c = 2;
                else if (rx_data == "L" || rx_data == "l") c = 3;
                else c = 4;
            end
            old = m_mode;
            m_lapv = 1'b0;
            acc = 1'b0;
            eb = "?";
            if (old == 2) m_mode = 0;
            else if (c == 1) begin
                m_mode = (old == 0) ? 1 : 0;
                acc = 1'b1;
                eb = (m_mode == 1) ? "R" : "S";
            end else if (c == 2 && old == 0) begin
                m_mode = 2; acc = 1'b1; eb = "C";
            end else if (c == 3 && old == 1) begin
                m_lap = stpw_data; m_lapv = 1'b1; exp_lap_q.push_back(stpw_data);
                acc = 1'b1; eb = "L";
            end
            if (c != 0 && (acc || uart)) begin
                arr_v = 1'b1;
                arr_b = acc ? eb : "?";
            end
        end
    end

    // Monitor: compares what the DUT presents against model and scoreboard queues
    always @(negedge clk) begin
        if (mon_en) begin
            chk("state", {30'd0, state}, m_mode);
            chk("run", {31'd0, run}, {31'd0, m_mode == 1});
            chk("clr", {31'd0, clr}, {31'd0, m_mode == 2});
            chk("lap_valid", {31'd0, lap_valid}, {31'd0, m_lapv});
            chk("lap_data", {8'd0, lap_data}, {8'd0, m_lap});
            chk("tx_ovf", {31'd0, tx_ovf}, {31'd0, m_ovf});
            chk("tx_start", {31'd0, tx_start}, {31'd0, buf_q.size() != 0 && !tx_busy});
            if (buf_q.size() != 0) chk("tx_data_pending", {24'd0, tx_data}, {24'd0, buf_q[0]});
            if (tx_start) begin
                if (exp_tx_q.size() == 0) chk("tx_expected_count", 32'd0, 32'd1);
                else chk("tx_byte", {24'd0, tx_data}, {24'd0, exp_tx_q.pop_front()});
            end
            if (lap_valid) begin
                if (exp_lap_q.size() == 0) chk("lap_expected_count", 32'd0, 32'd1);
                else chk("lap_capture", {8'd0, lap_data}, {8'd0, exp_lap_q.pop_front()});
            end
        end
    end

    task automatic step(input logic br, input logic bc, input logic rd, input logic [7:0] b);
        btn_run = br; btn_clr = bc; rx_done = rd; rx_data = b;
        @(posedge clk); #1;
        btn_run = 1'b0; btn_clr = 1'b0; rx_done = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    logic [7:0] chars [8] = '{8'h52, 8'h72, 8'h43, 8'h63, 8'h4C, 8'h6C, 8'h3F, 8'h41};

    initial begin
        rst = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        chk("reset_tx_data", {24'd0, tx_data}, 32'h00);
        chk("reset_run", {31'd0, run}, 32'd0);
        idle(3);
        // toggle into RUN, echo 'R' two cycles after the button
        step(1'b1, 1'b0, 1'b0, 8'h00);
        chk("run_next_cycle", {31'd0, run}, 32'd1);
        idle(1);
        chk("echo_R_start", {31'd0, tx_start}, 32'd1);
        chk("echo_R_byte", {24'd0, tx_data}, 32'h52);
        idle(2);
        // lap in RUN, then lap in STOP is ignored
        stpw_data = 24'h0A1234;
        step(1'b0, 1'b0, 1'b1, 8'h4C);
        chk("lap_value", {8'd0, lap_data}, 32'h0A1234);
        idle(2);
        step(1'b1, 1'b0, 1'b0, 8'h00);
        idle(3);
        stpw_data = 24'h155555;
        step(1'b0, 1'b0, 1'b1, 8'h6C);
        idle(3);
        chk("lap_held", {8'd0, lap_data}, 32'h0A1234);
        // clear ignored in RUN; then stop followed by 'c'
        step(1'b1, 1'b0, 1'b0, 8'h00);
        idle(2);
        step(1'b0, 1'b1, 1'b0, 8'h00);
        idle(2);
        step(1'b1, 1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 1'b1, 8'h63);
        chk("clr_pulse", {31'd0, clr}, 32'd1);
        idle(4);
        // button beats UART in the same cycle
        step(1'b1, 1'b0, 1'b1, 8'h43);
        idle(4);
        // busy transmitter: first echo held, the rest dropped
        tx_busy = 1'b1;
        step(1'b1, 1'b0, 1'b0, 8'h00); idle(1);
        step(1'b1, 1'b0, 1'b0, 8'h00); idle(1);
        step(1'b1, 1'b0, 1'b0, 8'h00); idle(3);
        chk("ovf_set", {31'd0, tx_ovf}, 32'd1);
        tx_busy = 1'b0;
        idle(4);
        // reset during CLEAR
        step(1'b0, 1'b1, 1'b0, 8'h00);
        rst = 1'b0;
        idle(1);
        rst = 1'b1;
        chk("rst_clr", {31'd0, clr}, 32'd0);
        chk("rst_ovf", {31'd0, tx_ovf}, 32'd0);
        idle(3);
        // randomized traffic
        for (int i = 0; i < 1500; i++) begin
            int r;
            rst = ($urandom_range(0, 149) != 0);
            tx_busy = ($urandom_range(0, 3) == 0);
            stpw_data = 24'($urandom);
            r = $urandom_range(0, 11);
            case (r)
                0: step(1'b1, 1'b0, 1'b0, 8'h00);
                1: step(1'b0, 1'b1, 1'b0, 8'h00);
                2: step(1'b1, 1'b1, 1'b0, 8'h00);
                3: step(1'b0, 1'b1, 1'b1, chars[$urandom_range(0, 7)]);
                4, 5, 6: step(1'b0, 1'b0, 1'b1, chars[$urandom_range(0, 7)]);
                7: step(1'b0, 1'b0, 1'b1, 8'($urandom));
                default: idle(1);
            endcase
        end
        rst = 1'b1;
        tx_busy = 1'b0;
        idle(6);
        chk("tx_drained", exp_tx_q.size(), 32'd0);
        chk("lap_drained", exp_lap_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
